trena_rx_medida: RTL
====================

Name: trena_rx_medida

Overview:
Serial receiver for the measurement packet that the digital tape-measure transmits on its saida_serial line. It deserializes 7E2 asynchronous characters and checks the packet format: three ASCII digits, most significant first, followed by '#'. Each valid packet is presented as 12-bit BCD with a one-cycle pronto pulse. It sits on the host/monitor side of the link and feeds displays or logic that consume measurements.

Parameters:
BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200 baud).
HALF_DIV, BAUD_DIV/2, cycles from the detected start edge to the start-bit mid-sample.

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-low reset
entrada_serial  input  1  serial line; idle high
medida  output  12  last valid packet as BCD: [11:8] hundreds, [7:4] tens, [3:0] units
pronto  output  1  one-cycle pulse, coincident with the medida update
erro  output  1  one-cycle pulse on any character or packet error
db_estado  output  4  current character-FSM state code

Behaviour:
- Reset (reset=0 at a rising edge):
  - medida=0x000, pronto=0, erro=0.
  - Packet index=0, shadow digits=0, FSM=INICIAL.
  - Reset has priority over all activity, including a frame in progress.
- entrada_serial passes through a 2-FF synchronizer before use. Its reset value is 1.
- Character format, LSB first:
  - start(0), 7 data bits, even parity bit, stop1(1), stop2(1).
  - Even parity means parity XOR data = 0.
- FSM states and db_estado codes:
  - INICIAL 0: one cycle, then go to ESPERA.
  - ESPERA 1: wait for the synchronized line =0, then clear the tick counter and go to START.
  - START 2: after HALF_DIV cycles, sample the line. If 1 (glitch), return to ESPERA. If 0, go to DADOS.
  - DADOS 3: sample every BAUD_DIV cycles, 7 samples into a shift register. Then go to PARIDADE.
  - PARIDADE 4: after BAUD_DIV cycles, sample the parity bit.
  - STOP1 5: after BAUD_DIV cycles, sample; must be 1.
  - STOP2 6: after BAUD_DIV cycles, sample; must be 1.
  - AVALIA 7: one cycle; run the packet check, then go to ESPERA.
  - FALHA E: reached on a stop bit =0. Wait for the line =1, then go to ESPERA. No new start is detected until then.
- Character error = parity mismatch or either stop bit =0.
  - In both cases erro pulses once and the packet index returns to 0.
  - A parity error is flagged in AVALIA, after the stop bits are sampled.
  - A stop-bit error is flagged on entry to FALHA.
- Packet check in AVALIA, on a valid character:
  - Index 0–2: the character must be 0x30–0x39. If so, store char[3:0] in shadow digit [index] and increment the index.
  - Index 0–2, character is '#' (0x23): erro pulse, index=0 (short packet).
  - Index 0–2, any other character: erro pulse, index=0.
  - Index 3, character is '#': medida <= shadow digits, pronto=1 for that one cycle, index=0.
  - Index 3, any other character: erro pulse, index=0. medida is unchanged.
- Output timing:
  - pronto and medida change together, one cycle after the stop2 sample of '#'.
  - erro and pronto are never asserted in the same cycle.
- Back-to-back characters must be accepted: a start bit immediately after stop2 is detected. ESPERA is entered in the cycle after AVALIA, well within the first half of the start bit.
- medida holds its value indefinitely between valid packets. Errors never alter it.
- Tick counter width is ceil(log2(BAUD_DIV)). It resets to 0 at each sample point.

Test Plan:
1. Send '1','2','3','#' (0x31,0x32,0x33,0x23) at BAUD_DIV=434 → exactly one pronto pulse, medida=0x123, erro never asserted.
2. Send '4','0','7','#' with no idle gap between characters → pronto once, medida=0x407. Then send "999#" → medida=0x999.
3. Send '1', then '2' with parity bit inverted, then '3','#' → erro pulse after the second character. The '#' then arrives at index 1, causing a second erro. medida keeps its previous value and no pronto occurs. A following "056#" yields medida=0x056.
4. Send '1','A','3','#' → erro in AVALIA of 'A'. Send "12#" → erro on '#'. Send "1234" → erro on '4'. No pronto in any case.
5. Send '5' with stop1 forced to 0 and the line held low for 3 bit times → db_estado=E, erro pulses once, nothing is received until the line returns high. Then "321#" → medida=0x321.
6. Assert reset=0 for one cycle midway through the DADOS state of the second character of "888#" → medida=0x000 and db_estado=0 on the next cycle. A clean "888#" afterwards gives medida=0x888. A 1-cycle low glitch on an idle line returns START→ESPERA with no erro.

Source files
------------

// File: rtl/trena_rx_medida.sv
// Receiver for the tape-measure packet: 7E2 serial characters, three ASCII digits then '#'.
// Each valid packet is published as 12-bit BCD with a one-cycle pronto pulse.
module trena_rx_medida #(
  parameter int BAUD_DIV = 434,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BAUD_LAST = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_DIV - 1);

  typedef enum logic [3:0] {
    INICIAL  = 4'h0,
    ESPERA   = 4'h1,
    START    = 4'h2,
    DADOS    = 4'h3,
    PARIDADE = 4'h4,
    STOP1    = 4'h5,
    STOP2    = 4'h6,
    AVALIA   = 4'h7,
    FALHA    = 4'hE
  } estado_t;

  function automatic logic paridade_ok(input logic [6:0] d, input logic p);
    return ~(^{p, d});
  endfunction

  function automatic logic eh_digito(input logic [6:0] c);
    return (c >= 7'h30) && (c <= 7'h39);
  endfunction

  estado_t        estado_q, estado_d;
  logic           sync1_q, sync2_q;
  logic [TW-1:0]  tick_q, tick_d;
  logic [2:0]     nbit_q, nbit_d;
  logic [6:0]     dado_q, dado_d;
  logic           par_q, par_d;
  logic [1:0]     idx_q, idx_d;
  logic [11:0]    dig_q, dig_d;
  logic [11:0]    medida_q, medida_d;
  logic           pronto_q, pronto_d;
  logic           erro_q, erro_d;
  logic           linha_s, fim_bit_s, fim_meio_s;

  assign linha_s    = sync2_q;
  assign fim_bit_s  = (tick_q == BAUD_LAST);
  assign fim_meio_s = (tick_q == HALF_LAST);

  // Character FSM, bit timing and packet assembly
  always_comb begin
    estado_d = estado_q;
    tick_d   = tick_q + TW'(1);
    nbit_d   = nbit_q;
    dado_d   = dado_q;
    par_d    = par_q;
    idx_d    = idx_q;
    dig_d    = dig_q;
    medida_d = medida_q;
    pronto_d = 1'b0;
    erro_d   = 1'b0;
    case (estado_q)
      INICIAL: begin
        tick_d   = '0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        tick_d = '0;
        if (!linha_s) estado_d = START;
        else          estado_d = ESPERA;
      end
      START: begin
        if (fim_meio_s) begin
          tick_d = '0;
          nbit_d = 3'd0;
          if (linha_s) estado_d = ESPERA;
          else         estado_d = DADOS;
        end else begin
          estado_d = START;
        end
      end
      DADOS: begin
        if (fim_bit_s) begin
          tick_d = '0;
          dado_d = {linha_s, dado_q[6:1]};
          nbit_d = nbit_q + 3'd1;
          if (nbit_q == 3'd6) estado_d = PARIDADE;
          else                estado_d = DADOS;
        end else begin
          estado_d = DADOS;
        end
      end
      PARIDADE: begin
        if (fim_bit_s) begin
          tick_d   = '0;
          par_d    = linha_s;
          estado_d = STOP1;
        end else begin
          estado_d = PARIDADE;
        end
      end
      STOP1, STOP2: begin
        if (fim_bit_s) begin
          tick_d = '0;
          if (!linha_s) begin
            estado_d = FALHA;
            erro_d   = 1'b1;
            idx_d    = 2'd0;
          end else if (estado_q == STOP1) begin
            estado_d = STOP2;
          end else begin
            estado_d = AVALIA;
          end
        end else begin
          estado_d = estado_q;
        end
      end
      AVALIA: begin
        tick_d   = '0;
        estado_d = ESPERA;
        if (!paridade_ok(dado_q, par_q)) begin
          erro_d = 1'b1;
          idx_d  = 2'd0;
        end else if (idx_q != 2'd3) begin
          if (eh_digito(dado_q)) begin
            case (idx_q)
              2'd0:    dig_d[11:8] = dado_q[3:0];
              2'd1:    dig_d[7:4]  = dado_q[3:0];
              default: dig_d[3:0]  = dado_q[3:0];
            endcase
            idx_d = idx_q + 2'd1;
          end else begin
            erro_d = 1'b1;
            idx_d  = 2'd0;
          end
        end else if (dado_q == 7'h23) begin
          medida_d = dig_q;
          pronto_d = 1'b1;
          idx_d    = 2'd0;
        end else begin
          erro_d = 1'b1;
          idx_d  = 2'd0;
        end
      end
      FALHA: begin
        tick_d = '0;
        if (linha_s) estado_d = ESPERA;
        else         estado_d = FALHA;
      end
      default: begin
        tick_d   = '0;
        estado_d = INICIAL;
      end
    endcase
  end

  // State and output registers; the line synchronizer idles high
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      estado_q <= INICIAL;
      tick_q   <= '0;
      nbit_q   <= 3'd0;
      dado_q   <= 7'd0;
      par_q    <= 1'b0;
      idx_q    <= 2'd0;
      dig_q    <= 12'h000;
      medida_q <= 12'h000;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      sync1_q  <= entrada_serial;
      sync2_q  <= sync1_q;
      estado_q <= estado_d;
      tick_q   <= tick_d;
      nbit_q   <= nbit_d;
      dado_q   <= dado_d;
      par_q    <= par_d;
      idx_q    <= idx_d;
      dig_q    <= dig_d;
      medida_q <= medida_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
    end
  end

  assign medida    = medida_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = estado_q;

endmodule
